zld_xcb_dec: RTL and testbench

//  Zero run-length decoder: inverse of the ZLE 7->8 bit encoder. Consumes the

---
 rtl/zld_xcb_dec.sv | 116 +++++++++++
 tb/tb_zld_xcb_dec.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zld_xcb_dec.sv
// ---------------------------------------------------------------------------
// zld_xcb_dec -- zero run-length decoder (inverse of the ZLE 7->8 encoder)
//
// Consumes 8-bit tokens and regenerates the original 7-bit symbols.
//   token[DW] == 0 : literal, emit token[DW-1:0]
//   token[DW] == 1 : emit token[DW-1:0] zero symbols (0 emits nothing)
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. A source holding valid must keep its data
// stable until the transfer; ready may depend combinationally on state.
//
// Ports
//   clock    : clock, all state changes on posedge
//   reset    : synchronous active-low reset
//   i_d      : input token, [DW] = run flag, [DW-1:0] = literal / run count
//   i_valid  : i_d valid
//   i_ready  : decoder accepts a token this cycle (combinational)
//   o_d      : decoded symbol (registered)
//   o_valid  : o_d valid (registered)
//   o_ready  : consumer takes o_d this cycle
//   busy     : high while a run is being expanded (state S_RUN); with only
//              two states this also exposes the full FSM state
// ---------------------------------------------------------------------------
module zld_xcb_dec #(
  parameter int DW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW:0]   i_d,
  input  logic          i_valid,
  output logic          i_ready,
  output logic [DW-1:0] o_d,
  output logic          o_valid,
  input  logic          o_ready,
  output logic          busy
);

  typedef enum logic {
    S_TAKE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [DW-1:0] ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] ZERO = '0;

  state_t        state, state_n;
  logic [DW-1:0] rem, rem_n;       // zeros still owed after the one in o_d
  logic [DW-1:0] o_d_n;
  logic          o_valid_n;

  logic          in_fire;
  logic          out_fire;
  logic [DW-1:0] tok_val;
  logic          tok_run;

  assign tok_val  = i_d[DW-1:0];
  assign tok_run  = i_d[DW];

  // A new token is only taken when the output register is free or being
  // drained this very cycle, which gives full rate with no bubble.
  assign i_ready  = (state == S_TAKE) && (!o_valid || o_ready);
  assign in_fire  = i_valid && i_ready;
  assign out_fire = o_valid && o_ready;
  assign busy     = (state == S_RUN);

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    o_d_n     = o_d;
    o_valid_n = o_valid;
    case (state)
      S_TAKE: begin
        if (in_fire) begin
          if (!tok_run) begin
            o_d_n     = tok_val;
            o_valid_n = 1'b1;
          end else if (tok_val != ZERO) begin
            // First zero of the run goes straight into o_d; rem counts the rest.
            o_d_n     = ZERO;
            o_valid_n = 1'b1;
            rem_n     = tok_val - ONE;
            if (tok_val > ONE) state_n = S_RUN;
          end else if (out_fire) begin
            // Empty run: token consumed, nothing new to present.
            o_valid_n = 1'b0;
          end
        end else if (out_fire) begin
          o_valid_n = 1'b0;
        end
      end
      S_RUN: begin
        // o_d stays zero and o_valid stays high until the run is exhausted.
        if (out_fire) begin
          rem_n = rem - ONE;
          if (rem == ONE) state_n = S_TAKE;
        end
      end
      default: state_n = S_TAKE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_TAKE;
      rem     <= ZERO;
      o_d     <= ZERO;
      o_valid <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      o_d     <= o_d_n;
      o_valid <= o_valid_n;
    end
  end

endmodule

// File: tb/tb_zld_xcb_dec.sv
// ---------------------------------------------------------------------------
// tb_zld_xcb_dec -- bench for the zero run-length decoder.
// Reference: every accepted token is expanded into the symbols it stands
// for and queued; every output transfer must match the queue head. For the
// end-to-end test the queue is filled with the original symbols instead, and
// tokens come from a behavioural ZLE encoder.
// ---------------------------------------------------------------------------
module tb_zld_xcb_dec;

  localparam int DW = 7;

  logic          clock;
  logic          reset;
  logic [DW:0]   i_d;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] o_d;
  logic          o_valid;
  logic          o_ready;
  logic          busy;

  zld_xcb_dec #(.DW(DW)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_d     (i_d),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_d     (o_d),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- bench state ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fire_d[$];
  int            fire_cyc[$];
  int            acc_cyc[$];
  int            busy_cnt;
  bit            model_from_tokens = 1'b1;
  int            ready_mode = 0;   // 0: always 1, 1: toggle, 2: random

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    fire_d.delete();
    fire_cyc.delete();
    acc_cyc.delete();
    busy_cnt = 0;
  endtask

  // ---------------- output-ready driver ----------------
  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = ~o_ready;
        default: o_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- token driver ----------------
  task automatic send_token(input logic [DW:0] t);
    int budget;
    i_d     = t;
    i_valid = 1'b1;
    budget  = 0;
    forever begin
      @(negedge clock);
      if (i_valid && i_ready) break;
      budget++;
      if (budget > 2000) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clock);
    #1;
    i_valid = 1'b0;
    i_d     = $urandom_range(0, 255);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 || busy || o_valid) begin
      @(posedge clock);
      #1;
      n++;
      if (n > budget) begin
        chk({name, "_drain_timeout"}, 0, 1);
        break;
      end
    end
    repeat (2) begin @(posedge clock); #1; end
  endtask

  // ---------------- behavioural ZLE encoder ----------------
  function automatic void zle_encode(input logic [DW-1:0] syms[$],
                                     output logic [DW:0] toks[$]);
    int i, run, chunk;
    toks.delete();
    i = 0;
    while (i < syms.size()) begin
      if (syms[i] != 0) begin
        toks.push_back({1'b0, syms[i]});
        i++;
      end else begin
        run = 0;
        while (i < syms.size() && syms[i] == 0) begin run++; i++; end
        while (run > 0) begin
          chunk = (run > 127) ? 127 : run;
          toks.push_back({1'b1, 7'(chunk)});
          run -= chunk;
        end
      end
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit            prev_stall = 0;
  logic [DW-1:0] prev_od = '0;
  bit            prev_busy = 0;
  bit            prev_ofire = 0;

  always @(negedge clock) begin
    bit ofire, ifire;
    logic [DW-1:0] e;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      prev_stall = 0;
      prev_busy  = 0;
      prev_ofire = 0;
    end else begin
      ofire = o_valid && o_ready;
      ifire = i_valid && i_ready;
      if (prev_stall) begin
        chk("stall_o_valid", int'(o_valid), 1);
        chk("stall_o_d", int'(o_d), int'(prev_od));
      end
      if (busy) chk("i_ready_in_run", int'(i_ready), 0);
      if (prev_busy && !busy) chk("busy_drop_on_fire", int'(prev_ofire), 1);
      if (ofire) begin
        fire_d.push_back(o_d);
        fire_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", int'(o_d), -1);
        end else begin
          e = exp_q.pop_front();
          chk("o_d", int'(o_d), int'(e));
        end
      end
      if (ifire) begin
        acc_cyc.push_back(cyc);
        if (model_from_tokens) begin
          if (!i_d[DW]) exp_q.push_back(i_d[DW-1:0]);
          else for (int k = 0; k < int'(i_d[DW-1:0]); k++) exp_q.push_back('0);
        end
      end
      if (busy) busy_cnt++;
      prev_stall = o_valid && !o_ready;
      prev_od    = o_d;
      prev_busy  = busy;
      prev_ofire = ofire;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] syms[$];
    logic [DW:0]   toks[$];
    logic [DW:0]   lits[3];
    int            n;

    reset   = 1'b0;
    i_valid = 1'b0;
    i_d     = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_o_valid", int'(o_valid), 0);
    chk("reset_o_d", int'(o_d), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_i_ready", int'(i_ready), 1);
    @(posedge clock);
    #1;

    // 1: literals back to back
    clear_logs();
    lits[0] = 8'h05; lits[1] = 8'h7F; lits[2] = 8'h01;
    for (int k = 0; k < 3; k++) send_token(lits[k]);
    wait_drain("t1", 50);
    chk("t1_count", fire_d.size(), 3);
    if (fire_d.size() == 3) begin
      chk("t1_d0", int'(fire_d[0]), 'h05);
      chk("t1_d1", int'(fire_d[1]), 'h7F);
      chk("t1_d2", int'(fire_d[2]), 'h01);
      chk("t1_latency", fire_cyc[0] - acc_cyc[0], 1);
      chk("t1_consecutive", fire_cyc[2] - fire_cyc[0], 2);
    end

    // 2: run of 5 then literal 0x03
    clear_logs();
    send_token(8'h85);
    send_token(8'h03);
    wait_drain("t2", 50);
    chk("t2_count", fire_d.size(), 6);
    if (fire_d.size() == 6 && acc_cyc.size() == 2) begin
      for (int k = 0; k < 5; k++) chk("t2_zero", int'(fire_d[k]), 0);
      chk("t2_lit", int'(fire_d[5]), 'h03);
      chk("t2_first_latency", fire_cyc[0] - acc_cyc[0], 1);
      chk("t2_consecutive", fire_cyc[5] - fire_cyc[0], 5);
      chk("t2_accept_with_5th", acc_cyc[1], fire_cyc[4]);
    end
    chk("t2_busy_cycles", busy_cnt, 4);

    // 3: run of 127 with toggling ready
    clear_logs();
    ready_mode = 1;
    send_token(8'hFF);
    wait_drain("t3", 1000);
    chk("t3_count", fire_d.size(), 127);
    n = 0;
    foreach (fire_d[k]) if (fire_d[k] != 0) n++;
    chk("t3_nonzero", n, 0);
    chk("t3_busy_end", int'(busy), 0);
    ready_mode = 0;
    repeat (2) begin @(posedge clock); #1; end

    // 4: empty run between literals
    clear_logs();
    send_token(8'h11);
    send_token(8'h80);
    send_token(8'h22);
    wait_drain("t4", 50);
    chk("t4_count", fire_d.size(), 2);
    if (fire_d.size() == 2) begin
      chk("t4_d0", int'(fire_d[0]), 'h11);
      chk("t4_d1", int'(fire_d[1]), 'h22);
    end

    // 5: reset in the middle of a run
    clear_logs();
    send_token(8'h8A);
    n = 0;
    while (fire_d.size() < 3 && n < 100) begin @(negedge clock); n++; end
    chk("t5_three_fired", fire_d.size(), 3);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    chk("t5_o_valid", int'(o_valid), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_i_ready", int'(i_ready), 1);
    @(posedge clock);
    #1;
    clear_logs();
    send_token(8'h09);
    wait_drain("t5", 50);
    chk("t5_count", fire_d.size(), 1);
    if (fire_d.size() == 1) chk("t5_lit", int'(fire_d[0]), 'h09);

    // 6: random symbols through the encoder, random backpressure and gaps
    ready_mode = 2;
    model_from_tokens = 1'b0;
    syms.delete();
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 2) != 0) begin
        syms.push_back(7'($urandom_range(1, 127)));
      end else begin
        n = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 300) : $urandom_range(1, 20);
        repeat (n) syms.push_back('0);
      end
    end
    zle_encode(syms, toks);
    foreach (syms[k]) exp_q.push_back(syms[k]);
    foreach (toks[k]) begin
      send_token(toks[k]);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
    wait_drain("t6", 20000);
    chk("t6_all_consumed", exp_q.size(), 0);

    // 7: random raw tokens (including empty runs) checked token by token
    model_from_tokens = 1'b1;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: send_token({1'b0, 7'($urandom_range(0, 127))});
        3:       send_token({1'b1, 7'($urandom_range(0, 3))});
        4:       send_token({1'b1, 7'($urandom_range(0, 40))});
        default: send_token({1'b1, 7'(($urandom_range(0, 3) == 0) ? 127 : $urandom_range(100, 127))});
      endcase
      if ($urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
    end
    wait_drain("t7", 20000);
    chk("t7_all_consumed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
